thash_fh: RTL and testbench

- Generalised tweakable-hash engine for the XMSS/WOTS hardware core.
- Computes either F (chaining, one n-bit input) or H (tree node, two n-bit inputs) under a per-operation mode bit.
- Derives the key and bitmasks through PRF calls on a shared external SHA-256 core, then issues the final core hash.
- Replaces the F-only wrapper and serves both the WOTS chain and the L-tree/treehash units.

---
 rtl/thash_fh.sv | 138 +++++++++++++
 tb/tb_thash_fh.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thash_fh.sv
// thash_fh: XMSS tweakable hash F/H; derives key and bitmasks via PRF calls on a shared SHA-256 core.
// Optional macro THASH_PERF_CNT_EN adds a cycle_count output latched on done.
module thash_fh #(
   parameter int KEY_LEN = 256,
   parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_F = KEY_LEN'(0),
   parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_H = KEY_LEN'(1),
   parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_PRF = KEY_LEN'(3)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   mode,
   input  logic [KEY_LEN-1:0]     input_key,
   input  logic [KEY_LEN-1:0]     input_data0,
   input  logic [KEY_LEN-1:0]     input_data1,
   input  logic [255:0]           hash_addr,
   output logic [KEY_LEN-1:0]     data_out,
   output logic                   done,
   output logic                   busy,
   output logic [255:0]           hash_addr_updated,
   input  logic                   hash_done,
   input  logic [KEY_LEN-1:0]     hash_data_out,
   output logic                   hash_start,
   output logic [4*KEY_LEN-1:0]   hash_data_in,
   output logic                   message_length
`ifdef THASH_PERF_CNT_EN
   ,
   output logic [31:0]            cycle_count
`endif
);
   typedef enum logic [2:0] {IDLE, PRF_KEY, PRF_BM0, PRF_BM1, CORE, FIN} state_t;
   state_t state, state_d;
   logic mode_q, accept, finish, issue, len_d, unused_addr;
   logic [KEY_LEN-1:0] seed, d0, d1, key, bm0;
   logic [31:0] kam_d;
   logic [4*KEY_LEN-1:0] msg_d;
   logic [223:0] addr_hi;

   // keyAndMask comes from the operation itself, never from the caller's address word 7
   assign unused_addr = ^hash_addr[31:0];
   assign addr_hi = hash_addr_updated[255:32];
   assign accept = start && (state == IDLE || state == FIN);
   assign finish = state == CORE && hash_done;

   function automatic logic [4*KEY_LEN-1:0] prf(input logic [KEY_LEN-1:0] sd, input logic [223:0] hi,
                                                 input logic [31:0] kam);
      prf = {XMSS_HASH_PADDING_PRF, sd, hi, kam, KEY_LEN'(0)};
   endfunction

   always_comb begin
      state_d = state;
      issue = 1'b0;
      kam_d = hash_addr_updated[31:0];
      msg_d = hash_data_in;
      len_d = message_length;
      case (state)
         IDLE, FIN: begin
            state_d = accept ? PRF_KEY : IDLE;
            if (accept) begin
               issue = 1'b1;
               kam_d = 32'd0;
               msg_d = prf(input_key, hash_addr[255:32], 32'd0);
               len_d = 1'b0;
            end
         end
         PRF_KEY: if (hash_done) begin
            state_d = PRF_BM0;
            issue = 1'b1;
            kam_d = 32'd1;
            msg_d = prf(seed, addr_hi, 32'd1);
         end
         PRF_BM0: if (hash_done) begin
            state_d = mode_q ? PRF_BM1 : CORE;
            issue = 1'b1;
            kam_d = mode_q ? 32'd2 : 32'd1;
            msg_d = mode_q ? prf(seed, addr_hi, 32'd2)
                           : {XMSS_HASH_PADDING_F, key, d0 ^ hash_data_out, KEY_LEN'(0)};
         end
         PRF_BM1: if (hash_done) begin
            state_d = CORE;
            issue = 1'b1;
            msg_d = {XMSS_HASH_PADDING_H, key, d0 ^ bm0, d1 ^ hash_data_out};
            len_d = 1'b1;
         end
         CORE: state_d = hash_done ? FIN : CORE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         mode_q <= 1'b0;
         seed <= '0;
         d0 <= '0;
         d1 <= '0;
         key <= '0;
         bm0 <= '0;
         data_out <= '0;
         done <= 1'b0;
         busy <= 1'b0;
         hash_addr_updated <= '0;
         hash_start <= 1'b0;
         hash_data_in <= '0;
         message_length <= 1'b0;
      end else begin
         state <= state_d;
         hash_start <= issue;
         hash_data_in <= msg_d;
         message_length <= len_d;
         hash_addr_updated <= {accept ? hash_addr[255:32] : addr_hi, kam_d};
         done <= finish;
         busy <= accept | (busy & ~finish);
         if (accept) begin
            mode_q <= mode;
            seed <= input_key;
            d0 <= input_data0;
            d1 <= input_data1;
         end
         if (state == PRF_KEY && hash_done) key <= hash_data_out;
         if (state == PRF_BM0 && hash_done) bm0 <= hash_data_out;
         if (finish) data_out <= hash_data_out;
      end
   end

`ifdef THASH_PERF_CNT_EN
   logic [31:0] cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         cycle_count <= '0;
      end else begin
         cnt <= accept ? 32'd0 : (busy && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
         if (done) cycle_count <= cnt;
      end
   end
`endif
endmodule

// File: tb/tb_thash_fh.sv
// tb_thash_fh: directed vector bench for thash_fh with a fixed 10-cycle SHA responder.
module tb_thash_fh;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic [255:0] input_key = '0, input_data0 = '0, input_data1 = '0, hash_addr = '0;
   logic [255:0] data_out, hash_addr_updated;
   logic done, busy, hash_start, message_length;
   logic hash_done = 1'b0;
   logic [255:0] hash_data_out = '0;
   logic [1023:0] hash_data_in;
`ifdef THASH_PERF_CNT_EN
   logic [31:0] cycle_count;
`endif

   thash_fh dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .input_key(input_key), .input_data0(input_data0), .input_data1(input_data1),
      .hash_addr(hash_addr), .data_out(data_out), .done(done), .busy(busy),
      .hash_addr_updated(hash_addr_updated), .hash_done(hash_done),
      .hash_data_out(hash_data_out), .hash_start(hash_start),
      .hash_data_in(hash_data_in), .message_length(message_length)
`ifdef THASH_PERF_CNT_EN
      , .cycle_count(cycle_count)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [255:0] AA = {64{4'hA}};
   localparam logic [255:0] P_F = 256'd0, P_H = 256'd1, P_PRF = 256'd3;

   int errors = 0, checks = 0, calls = 0;
   logic aa = 1'b0, inject = 1'b0, last_len = 1'b0;
   logic [1023:0] msgs [8];

   function automatic logic [255:0] h(input logic [1023:0] m, input logic a);
      h = a ? AA : m[1023:768] ^ {m[766:512], m[767]} ^ {m[509:256], m[511:510]}
                 ^ {m[252:0], m[255:253]} ^ {8{32'h9e3779b9}};
   endfunction

   // responder: digest appears 10 cycles after each hash_start pulse
   initial begin : sha
      int cnt;
      logic pend;
      logic [1023:0] cur;
      pend = 1'b0;
      cnt = 0;
      cur = '0;
      forever begin
         @(posedge clk);
         #1;
         hash_done = 1'b0;
         if (!reset_n) pend = 1'b0;
         else begin
            if (inject) begin
               hash_done = 1'b1;
               hash_data_out = {64{4'h3}};
               inject = 1'b0;
            end
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  hash_done = 1'b1;
                  hash_data_out = h(cur, aa);
                  pend = 1'b0;
               end
            end
            if (hash_start) begin
               cur = hash_data_in;
               if (calls < 8) msgs[calls] = hash_data_in;
               last_len = message_length;
               calls++;
               pend = 1'b1;
               cnt = 10;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic start_op(input logic m, input logic [255:0] s, input logic [255:0] a,
                           input logic [255:0] b, input logic [255:0] ad);
      mode = m;
      input_key = s;
      input_data0 = a;
      input_data1 = b;
      hash_addr = ad;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int t0, output int t);
      t = t0;
      while (done !== 1'b1 && t < 2000) begin
         step();
         t++;
      end
      chk("done_seen", {255'd0, done}, 256'd1);
   endtask

   task automatic ref_op(input logic m, input logic [255:0] s, input logic [255:0] a,
                         input logic [255:0] b, input logic [255:0] ad, input logic x,
                         output logic [255:0] res, output logic [1023:0] fin);
      logic [255:0] k, b0, b1;
      k = h({P_PRF, s, ad[255:32], 32'd0, 256'd0}, x);
      b0 = h({P_PRF, s, ad[255:32], 32'd1, 256'd0}, x);
      b1 = h({P_PRF, s, ad[255:32], 32'd2, 256'd0}, x);
      fin = m ? {P_H, k, a ^ b0, b ^ b1} : {P_F, k, a ^ b0, 256'd0};
      res = h(fin, x);
   endtask

   typedef struct {
      logic m;
      logic x;
      logic [255:0] s, a, b, ad;
      int lat, ncalls;
      logic len;
      logic [31:0] kam;
      int cyc;
   } vec_t;

   initial begin
      vec_t v [4];
      logic [255:0] res, res_b;
      logic [1023:0] fin, fin_b;
      logic [1023:0] last;
      logic seen;
      int t;
      v[0] = '{1'b0, 1'b0, {8{32'h01234567}}, {8{32'hdeadbeef}}, {8{32'h0badf00d}},
               {224'hc0ffee_1234_5678, 32'd5}, 34, 3, 1'b0, 32'd1, 33};
      v[1] = '{1'b1, 1'b1, {8{32'h11112222}}, {256{1'b1}}, 256'd0,
               {224'h77, 32'd9}, 45, 4, 1'b1, 32'd2, 44};
      v[2] = '{1'b0, 1'b0, {4{64'hfedcba9876543210}}, 256'h1, {256{1'b1}},
               {224'habcdef, 32'hffffffff}, 34, 3, 1'b0, 32'd1, 33};
      v[3] = '{1'b1, 1'b0, {8{32'h5a5a1234}}, {8{32'h13579bdf}}, {8{32'h2468ace0}},
               {224'h42, 32'd7}, 45, 4, 1'b1, 32'd2, 44};

      repeat (3) step();
      chk("rst_data_out", data_out, 256'd0);
      chk("rst_flags", {252'd0, done, busy, hash_start, message_length}, 256'd0);
      chk("rst_addr_upd", hash_addr_updated, 256'd0);
      chk("rst_msg_lo", hash_data_in[255:0], 256'd0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
         ref_op(v[i].m, v[i].s, v[i].a, v[i].b, v[i].ad, v[i].x, res, fin);
         calls = 0;
         aa = v[i].x;
         start_op(v[i].m, v[i].s, v[i].a, v[i].b, v[i].ad);
         chk($sformatf("v%0d_busy", i), {255'd0, busy}, 256'd1);
         chk($sformatf("v%0d_hs_first", i), {255'd0, hash_start}, 256'd1);
         wait_done(1, t);
         chk($sformatf("v%0d_latency", i), t, v[i].lat);
         chk($sformatf("v%0d_data_out", i), data_out, res);
         chk($sformatf("v%0d_busy_at_done", i), {255'd0, busy}, 256'd0);
         chk($sformatf("v%0d_calls", i), calls, v[i].ncalls);
         chk($sformatf("v%0d_len", i), {255'd0, last_len}, {255'd0, v[i].len});
         chk($sformatf("v%0d_kam0", i), {224'd0, msgs[0][287:256]}, 256'd0);
         chk($sformatf("v%0d_kam1", i), {224'd0, msgs[1][287:256]}, 256'd1);
         chk($sformatf("v%0d_prf_addr", i), {32'd0, msgs[0][511:288]}, {32'd0, v[i].ad[255:32]});
         last = msgs[v[i].ncalls - 1];
         for (int q = 0; q < 4; q++)
            chk($sformatf("v%0d_final_msg%0d", i, q), last[q*256 +: 256], fin[q*256 +: 256]);
         if (v[i].x) begin
            chk("aa_msg_pad", last[1023:768], 256'd1);
            chk("aa_msg_key", last[767:512], AA);
            chk("aa_msg_d0", last[511:256], {64{4'h5}});
            chk("aa_msg_d1", last[255:0], AA);
         end
         chk($sformatf("v%0d_addr_kam", i), {224'd0, hash_addr_updated[31:0]}, {224'd0, v[i].kam});
         chk($sformatf("v%0d_addr_hi", i), {32'd0, hash_addr_updated[255:32]}, {32'd0, v[i].ad[255:32]});
         step();
         chk($sformatf("v%0d_done_pulse", i), {255'd0, done}, 256'd0);
         chk($sformatf("v%0d_held", i), data_out, res);
`ifdef THASH_PERF_CNT_EN
         chk($sformatf("v%0d_cycle_count", i), {224'd0, cycle_count}, v[i].cyc);
`endif
         step();
      end

      // start during an operation is ignored
      ref_op(v[0].m, v[0].s, v[0].a, v[0].b, v[0].ad, 1'b0, res, fin);
      calls = 0;
      aa = 1'b0;
      start_op(v[0].m, v[0].s, v[0].a, v[0].b, v[0].ad);
      repeat (5) step();
      start_op(1'b1, v[3].s, v[3].a, v[3].b, v[3].ad);
      wait_done(7, t);
      chk("mid_latency", t, 34);
      chk("mid_data_out", data_out, res);
      chk("mid_calls", calls, 3);
      step();

      // start in the FIN cycle chains a new operation
      ref_op(v[3].m, v[3].s, v[3].a, v[3].b, v[3].ad, 1'b0, res_b, fin_b);
      calls = 0;
      start_op(v[2].m, v[2].s, v[2].a, v[2].b, v[2].ad);
      ref_op(v[2].m, v[2].s, v[2].a, v[2].b, v[2].ad, 1'b0, res, fin);
      wait_done(1, t);
      calls = 0;
      start_op(v[3].m, v[3].s, v[3].a, v[3].b, v[3].ad);
      chk("fin_hs_next", {255'd0, hash_start}, 256'd1);
      chk("fin_busy", {255'd0, busy}, 256'd1);
      chk("fin_old_held", data_out, res);
      repeat (20) step();
      chk("fin_old_held_mid", data_out, res);
      wait_done(21, t);
      chk("fin_new_latency", t, 45);
      chk("fin_new_data", data_out, res_b);
      chk("fin_new_calls", calls, 4);
      step();

      // asynchronous reset during PRF_BM0 aborts cleanly
      calls = 0;
      start_op(v[0].m, v[0].s, v[0].a, v[0].b, v[0].ad);
      for (int k = 0; k < 100 && calls < 2; k++) step();
      chk("rst_reached_bm0", calls, 2);
      chk("rst_hs_before", {255'd0, hash_start}, 256'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_flags", {253'd0, busy, hash_start, done}, 256'd0);
      step();
      reset_n = 1'b1;
      step();
      inject = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         step();
         seen = seen | done | busy | hash_start;
      end
      chk("abort_stray_done_ignored", {255'd0, seen}, 256'd0);
      chk("abort_data_out", data_out, 256'd0);
      ref_op(v[0].m, v[0].s, v[0].a, v[0].b, v[0].ad, 1'b0, res, fin);
      calls = 0;
      start_op(v[0].m, v[0].s, v[0].a, v[0].b, v[0].ad);
      wait_done(1, t);
      chk("post_rst_latency", t, 34);
      chk("post_rst_data", data_out, res);
      chk("post_rst_calls", calls, 3);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
